// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;
endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side (cache is slave) and memory-side (cache is master) bus bundles.
interface dcache_cpu_if #(parameter int ADDR_W = 8);
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [7:0]        WRITEDATA;
  logic [7:0]        READDATA;
  logic              BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
  modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if #(parameter int ADDR_W = 8);
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-3:0] MEM_ADDRESS;
  logic [31:0]       MEM_WRITEDATA;
  logic [31:0]       MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  input MEM_READDATA, MEM_BUSYWAIT);
  modport slave  (input MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/dcache_array.sv
// Line storage: valid/dirty with async reset, tag/data without; comb read, sync byte-write or line-fill.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int LINES   = 8,
  parameter  int TAG_W   = 3,
  localparam int INDEX_W = $clog2(LINES)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output logic               o_rd_valid,
  output logic               o_rd_dirty,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [BLOCK_W-1:0] o_rd_data,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic               i_byte_we,
  input  logic [OFFSET_W-1:0] i_byte_off,
  input  logic [7:0]         i_byte_data,
  input  logic               i_fill_we,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLOCK_W-1:0] i_fill_data
);
  logic [LINES-1:0]            r_valid;
  logic [LINES-1:0]            r_dirty;
  logic [LINES-1:0][TAG_W-1:0] r_tag;
  logic [LINES-1:0][3:0][7:0]  r_data;

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_dirty[i_wr_idx] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_fill_we) begin
      r_tag[i_wr_idx]  <= i_fill_tag;
      r_data[i_wr_idx] <= i_fill_data;
    end else if (i_byte_we) begin
      r_data[i_wr_idx][i_byte_off] <= i_byte_data;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit path is combinational, misses run an FSM.
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LINES  = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  state_e              r_state, w_next;
  logic                r_mem_read, r_mem_write;
  logic [ADDR_W-3:0]   r_mem_addr;
  logic [BLOCK_W-1:0]  r_mem_wdata, r_fill_data;
  logic [INDEX_W-1:0]  r_idx;
  logic [TAG_W-1:0]    r_req_tag;

  logic                w_req, w_hit, w_idle_hit, w_miss_start;
  logic                w_valid, w_dirty;
  logic [TAG_W-1:0]    w_line_tag, w_tag;
  logic [BLOCK_W-1:0]  w_line_data;
  logic [INDEX_W-1:0]  w_idx;
  logic [OFFSET_W-1:0] w_off;

  assign w_req        = cpu.READ | cpu.WRITE;
  assign w_off        = cpu.ADDRESS[OFFSET_W-1:0];
  assign w_idx        = cpu.ADDRESS[OFFSET_W +: INDEX_W];
  assign w_tag        = cpu.ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_hit        = w_valid & (w_line_tag == w_tag);
  assign w_idle_hit   = (r_state == IDLE) & w_hit;
  assign w_miss_start = (r_state == IDLE) & w_req & ~w_hit;

  assign cpu.BUSYWAIT  = w_req & ~w_idle_hit;
  assign cpu.READDATA  = (cpu.READ & w_hit) ? w_line_data[8*w_off +: 8] : 8'h00;

  assign mem.MEM_READ      = r_mem_read;
  assign mem.MEM_WRITE     = r_mem_write;
  assign mem.MEM_ADDRESS   = r_mem_addr;
  assign mem.MEM_WRITEDATA = r_mem_wdata;

  // Fill targets the line latched at miss time, so a dropped request cannot redirect it.
  dcache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_valid),
    .o_rd_dirty  (w_dirty),
    .o_rd_tag    (w_line_tag),
    .o_rd_data   (w_line_data),
    .i_wr_idx    ((r_state == UPDATE) ? r_idx : w_idx),
    .i_byte_we   (cpu.WRITE & w_idle_hit),
    .i_byte_off  (w_off),
    .i_byte_data (cpu.WRITEDATA),
    .i_fill_we   (r_state == UPDATE),
    .i_fill_tag  (r_req_tag),
    .i_fill_data (r_fill_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_miss_start) w_next = (w_valid & w_dirty) ? WRITEBACK : FETCH;
      WRITEBACK: if (!mem.MEM_BUSYWAIT) w_next = FETCH;
      FETCH:     if (!mem.MEM_BUSYWAIT) w_next = UPDATE;
      UPDATE:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fill_data <= '0;
      r_idx       <= '0;
      r_req_tag   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_miss_start) begin
          r_idx     <= w_idx;
          r_req_tag <= w_tag;
          if (w_valid & w_dirty) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= {w_line_tag, w_idx};
            r_mem_wdata <= w_line_data;
          end else begin
            r_mem_read <= 1'b1;
            r_mem_addr <= {w_tag, w_idx};
          end
        end
        WRITEBACK: if (!mem.MEM_BUSYWAIT) begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b1;
          r_mem_addr  <= {r_req_tag, r_idx};
        end
        // Capture the block here so UPDATE does not depend on memory holding its read data.
        FETCH: if (!mem.MEM_BUSYWAIT) begin
          r_mem_read  <= 1'b0;
          r_fill_data <= mem.MEM_READDATA;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_missed;
  logic [15:0] r_hit_cnt, r_miss_cnt;

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;

  // The hit cycle that finishes a missed access is not a hit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_missed   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_miss_start) begin
      r_missed <= 1'b1;
      if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end else if (r_state == IDLE) begin
      r_missed <= 1'b0;
      if (w_req & w_hit & ~r_missed & (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl against a 5-cycle-latency block memory model.
module tb_dcache_ctrl;
  localparam int LAT = 5;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  dcache_cpu_if #(.ADDR_W(8)) cpu ();
  dcache_mem_if #(.ADDR_W(8)) mem ();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_ctrl #(.ADDR_W(8), .LINES(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu),
    .mem   (mem)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
`endif
  );

  // Block memory: busy for LAT posedges of a request, completes on the next one.
  logic [31:0] mem_arr [0:63] = '{1: 32'hDDCCBBAA, 9: 32'h44332211, default: 32'h0};
  int  mcnt = 0;
  wire w_mreq = mem.MEM_READ | mem.MEM_WRITE;
  assign mem.MEM_BUSYWAIT = w_mreq && (mcnt != LAT);
  assign mem.MEM_READDATA = mem_arr[mem.MEM_ADDRESS];

  always @(posedge CLK) begin
    if (w_mreq) begin
      if (mcnt == LAT) begin
        mcnt <= 0;
        if (mem.MEM_WRITE) mem_arr[mem.MEM_ADDRESS] <= mem.MEM_WRITEDATA;
      end else mcnt <= mcnt + 1;
    end else mcnt <= 0;
  end

  typedef struct {
    logic        is_rd;
    logic [7:0]  rdata;
    logic        miss;
    logic        wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  fetch_addr;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int exp_h = 0, exp_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts on a negedge; holds the request until the DUT drops BUSYWAIT, then releases it.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input exp_t e);
    exp_t        got;
    logic        stalled = 0, saw_wb = 0, saw_rd = 0, overlap = 0;
    logic [5:0]  wb_a = '0, rd_a = '0;
    logic [31:0] wb_d = '0;
    sb.push_back(e);
    if (e.miss) exp_m++; else exp_h++;
    cpu.READ = rd; cpu.WRITE = wr; cpu.ADDRESS = addr; cpu.WRITEDATA = wdata;
    #1;
    for (int cyc = 0; cyc < 60 && cpu.BUSYWAIT; cyc++) begin
      stalled = 1;
      if (mem.MEM_READ & mem.MEM_WRITE) overlap = 1;
      if (mem.MEM_WRITE && !saw_wb) begin saw_wb = 1; wb_a = mem.MEM_ADDRESS; wb_d = mem.MEM_WRITEDATA; end
      if (mem.MEM_READ && !saw_rd) begin saw_rd = 1; rd_a = mem.MEM_ADDRESS; end
      @(negedge CLK); #1;
    end
    got = sb.pop_front();
    chk("busywait_done", cpu.BUSYWAIT, 0);
    chk("mem_idle_on_hit", {mem.MEM_READ, mem.MEM_WRITE}, 0);
    if (got.is_rd) chk("readdata", cpu.READDATA, got.rdata);
    chk("stalled", stalled, got.miss);
    chk("writeback_seen", saw_wb, got.wb);
    if (got.wb) begin
      chk("wb_addr", wb_a, got.wb_addr);
      chk("wb_data", wb_d, got.wb_data);
    end
    if (got.miss) chk("fetch_addr", rd_a, got.fetch_addr);
    chk("rd_wr_overlap", overlap, 0);
    @(negedge CLK);
    cpu.READ = 0; cpu.WRITE = 0;
  endtask

  initial begin
    cpu.READ = 0; cpu.WRITE = 0; cpu.ADDRESS = '0; cpu.WRITEDATA = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_mem_read", mem.MEM_READ, 0);
    chk("rst_mem_write", mem.MEM_WRITE, 0);
    chk("rst_mem_addr", mem.MEM_ADDRESS, 0);
    chk("rst_mem_wdata", mem.MEM_WRITEDATA, 0);
    chk("rst_busywait", cpu.BUSYWAIT, 0);
    chk("rst_readdata", cpu.READDATA, 0);
    @(negedge CLK); RESET = 1;
    @(negedge CLK);

    access(1, 0, 8'h05, 8'h00, '{1, 8'hBB, 1, 0, 6'h00, 32'h0, 6'h01});           // cold miss
    access(1, 0, 8'h06, 8'h00, '{1, 8'hCC, 0, 0, 6'h00, 32'h0, 6'h00});           // read hit
    access(0, 1, 8'h07, 8'h5A, '{0, 8'h00, 0, 0, 6'h00, 32'h0, 6'h00});           // write hit
    access(1, 0, 8'h07, 8'h00, '{1, 8'h5A, 0, 0, 6'h00, 32'h0, 6'h00});
    access(1, 0, 8'h27, 8'h00, '{1, 8'h44, 1, 1, 6'h01, 32'h5ACCBBAA, 6'h09});    // dirty eviction
    access(1, 0, 8'h05, 8'h00, '{1, 8'hBB, 1, 0, 6'h00, 32'h0, 6'h01});           // clean eviction
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, exp_h);
    chk("miss_count", miss_count, exp_m);
`endif

    // Reset while a fetch is outstanding.
    cpu.READ = 1; cpu.ADDRESS = 8'h45;
    begin
      int w = 0;
      while (!mem.MEM_READ && w < 20) begin @(negedge CLK); w++; end
    end
    chk("fetch_started", mem.MEM_READ, 1);
    chk("fetch_addr_45", mem.MEM_ADDRESS, 6'h11);
    RESET = 0; #1;
    chk("midrst_mem_read", mem.MEM_READ, 0);
    chk("midrst_mem_addr", mem.MEM_ADDRESS, 0);
    chk("midrst_busywait", cpu.BUSYWAIT, 1);
    cpu.READ = 0; #1;
    chk("midrst_busy_idle", cpu.BUSYWAIT, 0);
    chk("midrst_readdata", cpu.READDATA, 0);
    exp_h = 0; exp_m = 0;
    @(negedge CLK); RESET = 1;
    @(negedge CLK);

    access(1, 0, 8'h05, 8'h00, '{1, 8'hBB, 1, 0, 6'h00, 32'h0, 6'h01});           // lost after reset
    access(0, 1, 8'h46, 8'h77, '{0, 8'h00, 1, 0, 6'h00, 32'h0, 6'h11});           // write miss allocates
    access(1, 0, 8'h46, 8'h00, '{1, 8'h77, 0, 0, 6'h00, 32'h0, 6'h00});
    access(1, 0, 8'h05, 8'h00, '{1, 8'hBB, 1, 1, 6'h11, 32'h00770000, 6'h01});
`ifdef DCACHE_STATS_EN
    chk("hit_count_post", hit_count, exp_h);
    chk("miss_count_post", miss_count, exp_m);
`endif
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
